// File: rtl/ascii_recv_decode_pkg.sv
// Shared ASCII character codes, byte classes and decoder state encodings.
// The send-side logic imports the same definitions.
package ascii_recv_decode_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ESC  = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } dec_state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_TERM  = 2'd1,
        CLS_ESC   = 2'd2,
        CLS_OTHER = 2'd3
    } byte_cls_t;

    // Map a received byte onto the class that drives the decoder FSM.
    function automatic byte_cls_t classify_byte(input logic [7:0] b);
        byte_cls_t cls;
        if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
            cls = CLS_DIGIT;
        end else if (b == ASCII_CR || b == ASCII_LF) begin
            cls = CLS_TERM;
        end else if (b == ASCII_ESC) begin
            cls = CLS_ESC;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ascii_recv_decode.sv
// Decodes a stream of ASCII bytes from a UART receiver into unsigned decimal
// numbers terminated by CR or LF. Malformed or overlong numbers raise err and
// the rest of the line is discarded; ESC aborts the current line silently.
module ascii_recv_decode
    import ascii_recv_decode_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int VALUE_W    = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done,
    input  logic [7:0]         rx_data,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic               err,
    output logic               busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    dec_state_t         state_q, state_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    byte_cls_t          cls;
    logic [VALUE_W-1:0] digit_ext;
    logic [VALUE_W-1:0] acc_times10_plus;

    // Inline byte classification and the shift-add multiply-by-ten step.
    always_comb begin
        cls              = classify_byte(rx_data);
        digit_ext        = VALUE_W'(rx_data[3:0]);
        acc_times10_plus = (acc_q << 3) + (acc_q << 1) + digit_ext;
    end

    // Next-state and pulse generation; only bytes qualified by rx_done act.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (rx_done) begin
            if (cls == CLS_ESC) begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cls == CLS_DIGIT) begin
                            acc_d   = digit_ext;
                            cnt_d   = CNT_W'(1);
                            state_d = ST_ACCUM;
                        end else if (cls == CLS_OTHER) begin
                            err_d   = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_DISCARD;
                        end
                    end
                    ST_ACCUM: begin
                        if (cls == CLS_DIGIT) begin
                            if (cnt_q < CNT_MAX) begin
                                acc_d = acc_times10_plus;
                                cnt_d = cnt_q + CNT_W'(1);
                            end else begin
                                err_d   = 1'b1;
                                acc_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_DISCARD;
                            end
                        end else if (cls == CLS_TERM) begin
                            value_d = acc_q;
                            valid_d = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (cls == CLS_TERM) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset wins over any concurrent byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
